// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position timing generator gated by qualified PLL lock
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int LOCK_WAIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        locked,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        de,
   output logic [9:0]  h_pos,
   output logic [9:0]  v_pos,
   output logic        frame_start,
   output logic [11:0] rgb
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int QW       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RUN} state_t;

   state_t         state;
   logic           lock_m;
   logic           lock_s;
   logic [QW-1:0]  qcnt;
   logic [9:0]     h_cnt;
   logic [9:0]     v_cnt;
   logic           qual_done;
   logic           run_next;
   logic           h_last;
   logic           v_last;
   logic           de_now;

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [9:0] bar_px;
   logic [2:0] bar_idx;

   function automatic logic [11:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 12'hFFF;
         3'd1:    bar_colour = 12'hFF0;
         3'd2:    bar_colour = 12'h0FF;
         3'd3:    bar_colour = 12'h0F0;
         3'd4:    bar_colour = 12'hF0F;
         3'd5:    bar_colour = 12'hF00;
         3'd6:    bar_colour = 12'h00F;
         default: bar_colour = 12'h000;
      endcase
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= locked;
         lock_s <= lock_m;
      end
   end

   // The cycle that completes qualification already presents pixel (0,0), so RUN and the
   // first valid output register load on the same edge.
   assign qual_done = (state == QUALIFY) && (qcnt == QW'(LOCK_WAIT - 1));
   assign run_next  = lock_s && ((state == RUN) || qual_done);
   assign h_last    = (h_cnt == 10'(H_TOTAL - 1));
   assign v_last    = (v_cnt == 10'(V_TOTAL - 1));
   assign de_now    = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= WAIT_LOCK;
         qcnt        <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         de          <= 1'b0;
         h_pos       <= '0;
         v_pos       <= '0;
         frame_start <= 1'b0;
         rgb         <= '0;
`ifdef VGA_TEST_PATTERN_EN
         bar_px      <= '0;
         bar_idx     <= '0;
`endif
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= QUALIFY;
                  qcnt  <= '0;
               end
            end
            QUALIFY: begin
               if (!lock_s)        state <= WAIT_LOCK;
               else if (qual_done) state <= RUN;
               else                qcnt  <= qcnt + 1'b1;
            end
            RUN: begin
               if (!lock_s) state <= WAIT_LOCK;
            end
            default: state <= WAIT_LOCK;
         endcase

         if (run_next) begin
            h_pos       <= h_cnt;
            v_pos       <= v_cnt;
            hsync_n     <= !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
            vsync_n     <= !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
            de          <= de_now;
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            h_cnt       <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
`ifdef VGA_TEST_PATTERN_EN
            rgb <= de_now ? bar_colour(bar_idx) : 12'h000;
            if (h_last) begin
               bar_px  <= '0;
               bar_idx <= '0;
            end else if (bar_px == 10'(BAR_W - 1)) begin
               bar_px <= '0;
               if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_px <= bar_px + 10'd1;
            end
`else
            rgb <= '0;
`endif
         end else begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            de          <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
            frame_start <= 1'b0;
            rgb         <= '0;
`ifdef VGA_TEST_PATTERN_EN
            bar_px      <= '0;
            bar_idx     <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized lock/reset stimulus against a streak-based timing model
// Small geometry keeps whole frames short; LOCK_WAIT stays at its default.
module tb_vga_timing_gen;

   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
   localparam int LW = 1024;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                        12'hF0F, 12'hF00, 12'h00F, 12'h000};

   logic        clk = 1'b0;
   logic        rst;
   logic        locked;
   logic        hsync_n, vsync_n, de, frame_start;
   logic [9:0]  h_pos, v_pos;
   logic [11:0] rgb;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int streak = 0;
   bit hist [$];

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .LOCK_WAIT(LW)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
      .h_pos(h_pos), .v_pos(v_pos), .frame_start(frame_start), .rgb(rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Lock seen two edges late; output is active once LW+1 consecutive delayed samples are high.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         streak = 0;
      end else begin
         hist.push_back(locked);
         if (hist.size() > 3) void'(hist.pop_front());
         if (hist.size() == 3 && hist[0]) streak++;
         else streak = 0;
      end
   end

   always @(negedge clk) begin
      bit run;
      int t, h, v, bi;
      logic [11:0] exp_rgb;
      run = (streak >= LW + 1);
      t   = run ? streak - (LW + 1) : 0;
      h   = t % HT;
      v   = (t / HT) % VT;
      bi  = h / (HA / 8);
      if (bi > 7) bi = 7;
`ifdef VGA_TEST_PATTERN_EN
      exp_rgb = (run && h < HA && v < VA) ? BARS[bi] : 12'h000;
`else
      exp_rgb = 12'h000;
`endif
      check("h_pos", h_pos, run ? h : 0);
      check("v_pos", v_pos, run ? v : 0);
      check("hsync_n", hsync_n, !(run && h >= HA + HFP && h < HA + HFP + HS));
      check("vsync_n", vsync_n, !(run && v >= VA + VFP && v < VA + VFP + VS));
      check("de", de, run && h < HA && v < VA);
      check("frame_start", frame_start, run && h == 0 && v == 0);
      check("rgb", rgb, exp_rgb);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fs(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (frame_start) found = 1'b1;
      end
      check("fs_timeout", found, 1'b1);
   endtask

   initial begin
      bit ok;
      int rise, hs_low, de_cnt, vs_low, start;
      rst = 1'b1;
      locked = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hsync_n", hsync_n, 1'b1);
      check("rst_vsync_n", vsync_n, 1'b1);
      check("rst_de", de, 1'b0);
      check("rst_fs", frame_start, 1'b0);
      check("rst_hpos", h_pos, 10'd0);
      check("rst_vpos", v_pos, 10'd0);
      check("rst_rgb", rgb, 12'd0);

      // Lock qualification latency
      tick(1);
      rst = 1'b0;
      tick(3);
      locked = 1'b1;
      rise = cyc;
      wait_fs(LW + 100, ok);
      check("lock_latency", cyc - rise, LW + 3);
      check("first_h", h_pos, 10'd0);
      check("first_v", v_pos, 10'd0);

      // One line and one frame of sync/de accounting starting at (0,0)
      hs_low = 0; de_cnt = 0; vs_low = 0;
      start = cyc;
      for (int i = 0; i < HT * VT; i++) begin
         if (i < HT && !hsync_n) hs_low++;
         if (!vsync_n) vs_low++;
         if (de) de_cnt++;
         @(negedge clk);
      end
      check("hsync_low_per_line", hs_low, HS);
      check("vsync_low_per_frame", vs_low, VS * HT);
      check("de_per_frame", de_cnt, HA * VA);
      check("frame_period", cyc - start, HT * VT);
      check("frame_start_again", frame_start, 1'b1);

      // Single-cycle lock glitch part way through qualification
      tick(1);
      locked = 1'b0;
      tick(5);
      locked = 1'b1;
      tick(502);
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      rise = cyc;
      wait_fs(LW + 100, ok);
      check("glitch_latency", cyc - rise, LW + 3);

      // Mid-frame loss of lock, then re-lock
      ok = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !ok; i++) begin
         @(negedge clk);
         if (h_pos == 10'd5 && v_pos == 10'd3) ok = 1'b1;
      end
      check("reach_5_3", ok, 1'b1);
      @(posedge clk);
      #1 locked = 1'b0;
      tick(3);
      @(negedge clk);
      check("loss_de", de, 1'b0);
      check("loss_hpos", h_pos, 10'd0);
      check("loss_vpos", v_pos, 10'd0);
      check("loss_hsync_n", hsync_n, 1'b1);
      locked = 1'b1;
      rise = cyc;
      wait_fs(LW + 100, ok);
      check("relock_latency", cyc - rise, LW + 3);

      // Randomized lock on/off periods with occasional asynchronous reset pulses
      for (int it = 0; it < 12; it++) begin
         tick(1);
         locked = 1'b1;
         tick($urandom_range(200, 2200));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #3 rst = 1'b1;
            tick(2);
            rst = 1'b0;
         end
         locked = 1'b0;
         tick($urandom_range(1, 5));
      end
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
